// File: rtl/reg_debug_port.sv
// Debug master for the 8x16 CPU register file: halts the core, then dumps every
// register to an output stream or loads every register from an input stream.
module reg_debug_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREGS  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic              busy,
    output logic              done,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_idx,
    output logic              dump_last,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] rf_ra,
    output logic [ADDR_W-1:0] rf_rb,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] rf_ar,
    output logic [2:0]        dbg_state
);

    // Handshakes (cmd, dump, load): a transfer happens on a rising edge where
    // valid and ready are both high; a producer holds valid and its payload
    // stable until that edge, and ready never depends on valid in this block.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HALT = 3'd1,
        S_RD   = 3'd2,
        S_SEND = 3'd3,
        S_LOAD = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                op_q;
    logic [DATA_W-1:0]   dump_data_q;
    logic [ADDR_W-1:0]   dump_idx_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            op_q        <= 1'b0;
            dump_data_q <= '0;
            dump_idx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        idx_q   <= '0;
                        state_q <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (halt_ack) begin
                        state_q <= op_q ? S_LOAD : S_RD;
                    end
                end
                S_RD: begin
                    dump_data_q <= rf_ar;
                    dump_idx_q  <= idx_q;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (dump_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= S_RD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode the registered state only, so they are glitch-free.
    assign cmd_ready  = (state_q == S_IDLE);
    assign halt_req   = (state_q == S_HALT) || (state_q == S_RD) ||
                        (state_q == S_SEND) || (state_q == S_LOAD);
    assign busy       = halt_req;
    assign done       = (state_q == S_DONE);
    assign dump_valid = (state_q == S_SEND);
    assign load_ready = (state_q == S_LOAD);
    assign dump_data  = dump_data_q;
    assign dump_idx   = dump_idx_q;
    assign dump_last  = (state_q == S_SEND) && (dump_idx_q == LAST_IDX);
    assign dbg_state  = state_q;

    // The write path is combinational so a load word lands at the accepting edge.
    assign rf_ra    = (state_q == S_RD)   ? idx_q     : '0;
    assign rf_rb    = (state_q == S_LOAD) ? idx_q     : '0;
    assign rf_write = (state_q == S_LOAD) && load_valid;
    assign rf_data  = (state_q == S_LOAD) ? load_data : '0;

endmodule
